mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage controller sitting between the EX/MEM and MEM/WB pipeline registers. It takes the EX/MEM control bits, ALU result, store data and destination register and runs a req/ack handshake with the data memory for loads and stores. It produces the WB control, memory read data, ALU result and rd address consumed by MEM/WB, and stalls upstream stages while an access is outstanding. It also flags misaligned accesses and memory timeouts.

## Interface
Parameters:
- TIMEOUT, 16, max cycles spent in WAIT without dmem_ack before abort (≥1)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high
- valid_in  input  1  EX/MEM holds a live instruction
- M  input  2  M[1]=MemWrite, M[0]=MemRead; both set is treated as write
- WB  input  2  writeback control from EX/MEM
- ALU  input  32  ALU result / memory byte address
- wdata_in  input  32  store data
- rdAddr_in  input  5  destination register
- dmem_rdata  input  32  memory read data, valid when dmem_ack=1
- dmem_ack  input  1  memory completion, one-cycle pulse
- dmem_req  output  1  access request, held until ack or abort
- dmem_we  output  1  1=store, 0=load; valid while dmem_req=1
- dmem_addr  output  32  word-aligned address (latched)
- dmem_wdata  output  32  store data (latched)
- WB_out  output  2  to MEM/WB
- MemDout  output  32  to MEM/WB, load data
- ALU_out  output  32  to MEM/WB
- rdAddr_out  output  5  to MEM/WB
- stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- misaligned  output  1  one-cycle error pulse
- bus_error  output  1  one-cycle timeout pulse

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE, timeout counter 0, all latches 0.
- IDLE, valid_in=0 or M=0: outputs pass through combinationally (WB_out=WB, ALU_out=ALU, rdAddr_out=rdAddr_in, MemDout=0), stall=0. If valid_in=0, WB_out=0.
- IDLE, valid_in=1, M≠0, ALU[1:0]≠0: no request; WB_out=0, misaligned=1, stall=0, other outputs pass through; stay IDLE.
- IDLE, valid_in=1, M≠0, aligned: latch ALU, wdata_in, WB, rdAddr_in, we=M[1]; stall=1, WB_out=0; → WAIT.
- WAIT: dmem_req=1, dmem_we/addr/wdata from latches; stall=1, WB_out=0; counter increments each cycle.
  - dmem_ack=1: capture dmem_rdata (0 for stores) → RESP.
  - no ack and counter reaches TIMEOUT: → RESP with abort flag set.
- RESP: stall=0; WB_out=latched WB (0 if aborted), MemDout=captured data, ALU_out=latched address, rdAddr_out=latched rd; bus_error=1 if aborted. → IDLE, counter cleared.
- dmem_ack in IDLE or RESP is ignored. Upstream input changes during WAIT have no effect (latched).
- In all stall/abort/misaligned cases WB_out=0, so MEM/WB captures a bubble.

## Timing
- Reset (synchronous): next edge forces IDLE; dmem_req, dmem_we, stall, misaligned, bus_error, WB_out, MemDout, ALU_out, rdAddr_out, dmem_addr, dmem_wdata all 0 while reset=1 and after. Reset during WAIT drops dmem_req at that edge; a later ack is ignored.
- Non-memory op: 0 added latency, no stall.
- Memory op with ack after k WAIT cycles (k≥1; ack in first WAIT cycle is k=1): stall high for 1+k cycles; RESP presents the result in cycle k+2 after entry; MEM/WB captures it at the end of RESP, and EX/MEM advances at the same edge.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then RESP with bus_error=1.
- Ack coincident with the timeout cycle: the ack wins and there is no bus_error.
- Back-to-back memory ops: the second is detected in the IDLE cycle after RESP. Minimum period is 3 cycles per access.

## Test plan
- ALU op: valid_in=1, M=0, WB=2'b10, ALU=32'h1234, rdAddr_in=5 -> same cycle WB_out=2'b10, ALU_out=32'h1234, rdAddr_out=5, stall=0, dmem_req=0.
- Load, ack after 3 cycles: M=01, ALU=32'h100, WB=2'b11, rd=8, dmem_rdata=32'hDEADBEEF -> dmem_req high 3 cycles with addr 32'h100, dmem_we=0; stall high 4 cycles; RESP shows MemDout=32'hDEADBEEF, WB_out=2'b11, rdAddr_out=8.
- Store, ack first WAIT cycle: M=10, ALU=32'h20, wdata_in=32'hCAFE0001 -> dmem_we=1, dmem_wdata=32'hCAFE0001; stall 2 cycles; RESP MemDout=0.
- Misaligned load: ALU=32'h102, M=01 -> misaligned=1 one cycle, WB_out=0, dmem_req=0, stall=0.
- Timeout, TIMEOUT=4, no ack -> dmem_req high exactly 4 cycles, then RESP with bus_error=1, WB_out=0, stall=0; the next IDLE accepts a new op.
- Reset in WAIT cycle 2 then ack one cycle later -> dmem_req=0 after reset edge, all outputs 0, late ack causes no transition.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage req/ack controller with stall, misalignment and timeout reporting
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [1:0]  M,
    input  logic [1:0]  WB,
    input  logic [31:0] ALU,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  rdAddr_in,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [1:0]  WB_out,
    output logic [31:0] MemDout,
    output logic [31:0] ALU_out,
    output logic [4:0]  rdAddr_out,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
    logic [1:0]  wb_q, wb_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d, abort_q, abort_d;
    logic        mem_op, aligned;
    // next-state, latch capture and MEM/WB-facing outputs; reset forces every output low
    always_comb begin
        mem_op     = valid_in && (M != 2'b00);
        aligned    = ALU[1:0] == 2'b00;
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        wb_d       = wb_q;
        rd_d       = rd_q;
        we_d       = we_q;
        abort_d    = abort_q;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
        WB_out     = 2'b00;
        MemDout    = 32'd0;
        ALU_out    = addr_q;
        rdAddr_out = rd_q;
        stall      = 1'b0;
        misaligned = 1'b0;
        bus_error  = 1'b0;
        case (state_q)
            IDLE: begin
                WB_out     = (valid_in && M == 2'b00) ? WB : 2'b00;
                ALU_out    = ALU;
                rdAddr_out = rdAddr_in;
                misaligned = mem_op && !aligned;
                stall      = mem_op && aligned;
                if (mem_op && aligned) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    addr_d  = ALU;
                    wdata_d = wdata_in;
                    wb_d    = WB;
                    rd_d    = rdAddr_in;
                    we_d    = M[1];
                    data_d  = 32'd0;
                    abort_d = 1'b0;
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                dmem_we  = we_q;
                stall    = 1'b1;
                cnt_d    = cnt_q + CW'(1);
                if (dmem_ack) begin
                    data_d  = we_q ? 32'd0 : dmem_rdata;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                WB_out    = abort_q ? 2'b00 : wb_q;
                MemDout   = data_q;
                bus_error = abort_q;
                state_d   = IDLE;
                cnt_d     = '0;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            dmem_addr  = 32'd0;
            dmem_wdata = 32'd0;
            WB_out     = 2'b00;
            MemDout    = 32'd0;
            ALU_out    = 32'd0;
            rdAddr_out = 5'd0;
            stall      = 1'b0;
            misaligned = 1'b0;
            bus_error  = 1'b0;
        end
    end
    // state and latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
            wb_q    <= 2'b00;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            wb_q    <= wb_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            abort_q <= abort_d;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scenario bench for mem_access_unit with TIMEOUT=4
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset, valid_in, dmem_ack;
    logic [1:0]  M, WB;
    logic [31:0] ALU, wdata_in, dmem_rdata;
    logic [4:0]  rdAddr_in;
    logic        dmem_req, dmem_we, stall, misaligned, bus_error;
    logic [31:0] dmem_addr, dmem_wdata, MemDout, ALU_out;
    logic [1:0]  WB_out;
    logic [4:0]  rdAddr_out;
    logic [4:0]  ctl;
    logic [172:0] all_out;
    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .M(M), .WB(WB), .ALU(ALU),
        .wdata_in(wdata_in), .rdAddr_in(rdAddr_in), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .WB_out(WB_out), .MemDout(MemDout), .ALU_out(ALU_out), .rdAddr_out(rdAddr_out),
        .stall(stall), .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;
    // {req, we, stall, misaligned, bus_error}
    assign ctl = {dmem_req, dmem_we, stall, misaligned, bus_error};
    assign all_out = {ctl, WB_out, MemDout, ALU_out, rdAddr_out, dmem_addr, dmem_wdata};

    task automatic idle_inputs();
        valid_in = 0; M = 0; WB = 0; ALU = 0; wdata_in = 0; rdAddr_in = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wb, input logic [4:0] rd);
        @(negedge clk);
        valid_in = 1; M = m; ALU = a; wdata_in = wd; WB = wb; rdAddr_in = rd; #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; valid_in = 1; M = 0; WB = 2'b11; ALU = 32'h55; rdAddr_in = 3; #1;
        n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_hold outputs=%h exp=0", all_out); end
        @(negedge clk);
        reset = 0; idle_inputs(); #1;
        n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_after outputs=%h exp=0", all_out); end
    endtask

    task automatic test_alu_op();
        issue(2'b00, 32'h1234, 0, 2'b10, 5);
        n_cmp++; if ({ctl, WB_out, ALU_out, rdAddr_out, MemDout} !== {5'b0, 2'b10, 32'h1234, 5'd5, 32'd0}) begin
            n_bad++; $display("FAIL alu_op ctl=%b wb=%b alu=%h rd=%0d md=%h exp ctl=0 wb=10 alu=1234 rd=5 md=0", ctl, WB_out, ALU_out, rdAddr_out, MemDout); end
        @(negedge clk);
        valid_in = 0; #1;
        n_cmp++; if ({ctl, WB_out, ALU_out} !== {5'b0, 2'b00, 32'h1234}) begin
            n_bad++; $display("FAIL alu_invalid ctl=%b wb=%b alu=%h exp ctl=0 wb=00 alu=1234", ctl, WB_out, ALU_out); end
        idle_inputs();
    endtask

    task automatic test_load();
        issue(2'b01, 32'h100, 0, 2'b11, 8);
        n_cmp++; if ({ctl, WB_out} !== {5'b00100, 2'b00}) begin
            n_bad++; $display("FAIL load_accept ctl=%b wb=%b exp ctl=00100 wb=00", ctl, WB_out); end
        @(negedge clk);
        valid_in = 1; M = 2'b10; ALU = 32'h200; wdata_in = 32'h77; WB = 2'b01; rdAddr_in = 1; #1;
        n_cmp++; if ({ctl, dmem_addr, WB_out} !== {5'b10100, 32'h100, 2'b00}) begin
            n_bad++; $display("FAIL load_wait1 ctl=%b addr=%h wb=%b exp ctl=10100 addr=100 wb=00", ctl, dmem_addr, WB_out); end
        @(negedge clk); #1;
        n_cmp++; if ({ctl, dmem_addr} !== {5'b10100, 32'h100}) begin
            n_bad++; $display("FAIL load_wait2 ctl=%b addr=%h exp ctl=10100 addr=100", ctl, dmem_addr); end
        @(negedge clk);
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; #1;
        n_cmp++; if (ctl !== 5'b10100) begin n_bad++; $display("FAIL load_wait3 ctl=%b exp 10100", ctl); end
        @(negedge clk);
        idle_inputs(); #1;
        n_cmp++; if ({ctl, MemDout, WB_out, rdAddr_out, ALU_out} !== {5'b0, 32'hDEADBEEF, 2'b11, 5'd8, 32'h100}) begin
            n_bad++; $display("FAIL load_resp ctl=%b md=%h wb=%b rd=%0d alu=%h exp ctl=0 md=deadbeef wb=11 rd=8 alu=100", ctl, MemDout, WB_out, rdAddr_out, ALU_out); end
        @(negedge clk); #1;
        n_cmp++; if ({ctl, WB_out, MemDout} !== {5'b0, 2'b00, 32'd0}) begin
            n_bad++; $display("FAIL load_idle ctl=%b wb=%b md=%h exp all 0", ctl, WB_out, MemDout); end
    endtask

    task automatic test_store();
        issue(2'b10, 32'h20, 32'hCAFE0001, 2'b01, 2);
        n_cmp++; if (ctl !== 5'b00100) begin n_bad++; $display("FAIL store_accept ctl=%b exp 00100", ctl); end
        @(negedge clk);
        idle_inputs(); dmem_ack = 1; dmem_rdata = 32'h99; #1;
        n_cmp++; if ({ctl, dmem_addr, dmem_wdata} !== {5'b11100, 32'h20, 32'hCAFE0001}) begin
            n_bad++; $display("FAIL store_wait ctl=%b addr=%h wd=%h exp ctl=11100 addr=20 wd=cafe0001", ctl, dmem_addr, dmem_wdata); end
        @(negedge clk);
        dmem_ack = 0; #1;
        n_cmp++; if ({ctl, MemDout, WB_out, ALU_out} !== {5'b0, 32'd0, 2'b01, 32'h20}) begin
            n_bad++; $display("FAIL store_resp ctl=%b md=%h wb=%b alu=%h exp ctl=0 md=0 wb=01 alu=20", ctl, MemDout, WB_out, ALU_out); end
    endtask

    task automatic test_misaligned();
        issue(2'b01, 32'h102, 0, 2'b11, 4);
        n_cmp++; if ({ctl, WB_out, ALU_out} !== {5'b00010, 2'b00, 32'h102}) begin
            n_bad++; $display("FAIL misaligned ctl=%b wb=%b alu=%h exp ctl=00010 wb=00 alu=102", ctl, WB_out, ALU_out); end
        @(negedge clk);
        idle_inputs(); #1;
        n_cmp++; if (ctl !== 5'b0) begin n_bad++; $display("FAIL misaligned_after ctl=%b exp 00000", ctl); end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        issue(2'b01, 32'h40, 0, 2'b11, 9);
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            #1; if (ctl === 5'b10100) req_cycles++;
            @(negedge clk);
        end
        #1;
        n_cmp++; if (req_cycles !== 4) begin n_bad++; $display("FAIL timeout_len req_cycles=%0d exp 4", req_cycles); end
        n_cmp++; if ({ctl, WB_out, MemDout} !== {5'b00001, 2'b00, 32'd0}) begin
            n_bad++; $display("FAIL timeout_resp ctl=%b wb=%b md=%h exp ctl=00001 wb=00 md=0", ctl, WB_out, MemDout); end
        issue(2'b01, 32'h44, 0, 2'b10, 6);
        n_cmp++; if (ctl !== 5'b00100) begin n_bad++; $display("FAIL timeout_next_accept ctl=%b exp 00100", ctl); end
        @(negedge clk);
        idle_inputs(); dmem_ack = 1; dmem_rdata = 32'h1111; #1;
        @(negedge clk);
        dmem_ack = 0; #1;
        n_cmp++; if ({ctl, MemDout, WB_out, rdAddr_out} !== {5'b0, 32'h1111, 2'b10, 5'd6}) begin
            n_bad++; $display("FAIL timeout_next_resp ctl=%b md=%h wb=%b rd=%0d exp ctl=0 md=1111 wb=10 rd=6", ctl, MemDout, WB_out, rdAddr_out); end
    endtask

    task automatic test_ack_at_timeout();
        issue(2'b01, 32'h80, 0, 2'b01, 7);
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        dmem_ack = 1; dmem_rdata = 32'h5A5A; #1;
        n_cmp++; if (ctl !== 5'b10100) begin n_bad++; $display("FAIL ackto_wait4 ctl=%b exp 10100", ctl); end
        @(negedge clk);
        dmem_ack = 0; #1;
        n_cmp++; if ({ctl, MemDout, WB_out} !== {5'b0, 32'h5A5A, 2'b01}) begin
            n_bad++; $display("FAIL ackto_resp ctl=%b md=%h wb=%b exp ctl=0 md=5a5a wb=01", ctl, MemDout, WB_out); end
    endtask

    task automatic test_back_to_back();
        issue(2'b01, 32'hA0, 0, 2'b11, 10);
        @(negedge clk);
        idle_inputs(); dmem_ack = 1; dmem_rdata = 32'h12345678; #1;
        @(negedge clk);
        dmem_ack = 0; valid_in = 1; M = 2'b11; ALU = 32'h30; wdata_in = 32'hBEEF; WB = 2'b01; rdAddr_in = 11; #1;
        n_cmp++; if ({ctl, MemDout, rdAddr_out} !== {5'b0, 32'h12345678, 5'd10}) begin
            n_bad++; $display("FAIL b2b_resp1 ctl=%b md=%h rd=%0d exp ctl=0 md=12345678 rd=10", ctl, MemDout, rdAddr_out); end
        @(negedge clk); #1;
        n_cmp++; if (ctl !== 5'b00100) begin n_bad++; $display("FAIL b2b_accept2 ctl=%b exp 00100", ctl); end
        @(negedge clk);
        idle_inputs(); dmem_ack = 1; #1;
        n_cmp++; if ({ctl, dmem_addr, dmem_wdata} !== {5'b11100, 32'h30, 32'hBEEF}) begin
            n_bad++; $display("FAIL b2b_wait2 ctl=%b addr=%h wd=%h exp ctl=11100 addr=30 wd=beef", ctl, dmem_addr, dmem_wdata); end
        @(negedge clk);
        dmem_ack = 0; #1;
        n_cmp++; if ({ctl, MemDout, WB_out, rdAddr_out} !== {5'b0, 32'd0, 2'b01, 5'd11}) begin
            n_bad++; $display("FAIL b2b_resp2 ctl=%b md=%h wb=%b rd=%0d exp ctl=0 md=0 wb=01 rd=11", ctl, MemDout, WB_out, rdAddr_out); end
    endtask

    task automatic test_reset_in_wait();
        issue(2'b01, 32'hC0, 0, 2'b11, 12);
        @(negedge clk);
        idle_inputs(); #1;
        n_cmp++; if (ctl !== 5'b10100) begin n_bad++; $display("FAIL rstwait_wait1 ctl=%b exp 10100", ctl); end
        @(negedge clk);
        reset = 1; #1;
        n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL rstwait_hold outputs=%h exp 0", all_out); end
        @(negedge clk);
        reset = 0; dmem_ack = 1; dmem_rdata = 32'hFFFF; #1;
        n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL rstwait_after outputs=%h exp 0", all_out); end
        @(negedge clk);
        dmem_ack = 0; #1;
        n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL rstwait_late_ack outputs=%h exp 0", all_out); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_at_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
